// File: rtl/rport_arbiter.sv
// rport_arbiter
//   Two read ports (port 0 = instruction fetch, port 1 = loader/debug) share
//   one memory read channel. At most one memory read is outstanding. Each read
//   either completes with memory data or, after TMO cycles without MVld,
//   completes with an error flag and zero data.
//
//   Build option: define RPORT_ARB_RR_EN to resolve simultaneous requests
//   round-robin. If it is undefined, port 0 always wins a tie and no pointer
//   flop exists.
//
// Parameters
//   AW   address width
//   DW   data width
//   TMO  response timeout in cycles (2..255)
//
// Ports
//   clk              sole clock, rising edge
//   rst              asynchronous active-high reset
//   R0Rdy / R1Rdy    port read request, held until that port's Vld
//   R0Addr / R1Addr  port read address
//   R0Vld / R1Vld    one-cycle response strobe
//   R0Data / R1Data  read data, valid with Vld (zero on timeout)
//   R0Err / R1Err    timeout flag, valid with Vld
//   MRdy             shared memory read request
//   MAddr            shared memory read address, latched at grant
//   MVld             memory response strobe
//   MData            memory read data
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no read outstanding; grant evaluated every cycle
// S_WAIT | memory read issued; waiting for MVld or timeout
// S_RESP | one-cycle response to the winner; no grant evaluated
module rport_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          R0Rdy,
  input  logic [AW-1:0] R0Addr,
  output logic          R0Vld,
  output logic [DW-1:0] R0Data,
  output logic          R0Err,
  input  logic          R1Rdy,
  input  logic [AW-1:0] R1Addr,
  output logic          R1Vld,
  output logic [DW-1:0] R1Data,
  output logic          R1Err,
  output logic          MRdy,
  output logic [AW-1:0] MAddr,
  input  logic          MVld,
  input  logic [DW-1:0] MData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Down-counter: loaded with TMO-1 at grant, timeout fires when it is zero
  // in WAIT, which gives exactly TMO cycles of MRdy.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state_q, state_d;
  logic          win_q, win_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
  logic          any_req;
  logic          grant_sel;

  logic          mrdy_d;
  logic [AW-1:0] maddr_d;
  logic          r0_vld_d, r1_vld_d;
  logic          r0_err_d, r1_err_d;
  logic [DW-1:0] r0_data_d, r1_data_d;

  assign any_req = R0Rdy | R1Rdy;

`ifdef RPORT_ARB_RR_EN
  // last_q remembers the most recently granted port; on a tie the other
  // port wins. Reset value 1 makes port 0 win the first tie.
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (state_q == S_IDLE && any_req) begin
      last_q <= grant_sel;
    end
  end

  always_comb begin
    if (R0Rdy && R1Rdy) begin
      grant_sel = ~last_q;
    end else begin
      grant_sel = R1Rdy;
    end
  end
`else
  // Port 1 is granted only when port 0 is not asking.
  assign grant_sel = ~R0Rdy;
`endif

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    tmo_cnt_d = tmo_cnt_q;
    mrdy_d    = MRdy;
    maddr_d   = MAddr;
    r0_vld_d  = 1'b0;
    r1_vld_d  = 1'b0;
    r0_err_d  = 1'b0;
    r1_err_d  = 1'b0;
    r0_data_d = '0;
    r1_data_d = '0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d     = grant_sel;
          maddr_d   = grant_sel ? R1Addr : R0Addr;
          mrdy_d    = 1'b1;
          tmo_cnt_d = TMO_LAST;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        // MVld is tested first so it wins over a coincident timeout.
        if (MVld) begin
          mrdy_d  = 1'b0;
          state_d = S_RESP;
          if (win_q) begin
            r1_vld_d  = 1'b1;
            r1_data_d = MData;
          end else begin
            r0_vld_d  = 1'b1;
            r0_data_d = MData;
          end
        end else if (tmo_cnt_q == 8'd0) begin
          mrdy_d  = 1'b0;
          state_d = S_RESP;
          if (win_q) begin
            r1_vld_d = 1'b1;
            r1_err_d = 1'b1;
          end else begin
            r0_vld_d = 1'b1;
            r0_err_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q - 8'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        mrdy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      tmo_cnt_q <= 8'd0;
      MRdy      <= 1'b0;
      MAddr     <= '0;
      R0Vld     <= 1'b0;
      R1Vld     <= 1'b0;
      R0Err     <= 1'b0;
      R1Err     <= 1'b0;
      R0Data    <= '0;
      R1Data    <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      tmo_cnt_q <= tmo_cnt_d;
      MRdy      <= mrdy_d;
      MAddr     <= maddr_d;
      R0Vld     <= r0_vld_d;
      R1Vld     <= r1_vld_d;
      R0Err     <= r0_err_d;
      R1Err     <= r1_err_d;
      R0Data    <= r0_data_d;
      R1Data    <= r1_data_d;
    end
  end

endmodule

// File: tb/tb_rport_arbiter.sv
module tb_rport_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 4;
  localparam int NCYC = 4000;

`ifdef RPORT_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          R0Rdy, R1Rdy;
  logic [AW-1:0] R0Addr, R1Addr;
  logic          R0Vld, R1Vld, R0Err, R1Err;
  logic [DW-1:0] R0Data, R1Data;
  logic          MRdy;
  logic [AW-1:0] MAddr;
  logic          MVld;
  logic [DW-1:0] MData;

  always #5 clk = ~clk;

  rport_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .R0Rdy (R0Rdy),
    .R0Addr(R0Addr),
    .R0Vld (R0Vld),
    .R0Data(R0Data),
    .R0Err (R0Err),
    .R1Rdy (R1Rdy),
    .R1Addr(R1Addr),
    .R1Vld (R1Vld),
    .R1Data(R1Data),
    .R1Err (R1Err),
    .MRdy  (MRdy),
    .MAddr (MAddr),
    .MVld  (MVld),
    .MData (MData)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } mreq_t;

  typedef struct {
    int            cyc;
    bit            port;
    logic [DW-1:0] data;
    bit            err;
  } resp_t;

  mreq_t mreq_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic record_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Reference model: transaction view of the arbiter.
  //   m_busy     0 = free, 1 = memory read in flight, 2 = response being shown
  //   m_waited   WAIT cycles already spent without a memory answer
  int    m_busy   = 0;
  int    m_waited = 0;
  bit    m_win    = 1'b0;
  bit    m_last   = 1'b1;
  bit    m_pick;
  mreq_t m_req;
  resp_t m_rsp;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy   = 0;
      m_waited = 0;
      m_last   = 1'b1;
    end else if (m_busy == 0) begin
      if (R0Rdy || R1Rdy) begin
        if (R0Rdy && R1Rdy) m_pick = RR_MODE ? !m_last : 1'b0;
        else                m_pick = R1Rdy;
        m_last      = m_pick;
        m_win       = m_pick;
        m_waited    = 0;
        m_busy      = 1;
        m_req.cyc   = cyc;
        m_req.addr  = m_pick ? R1Addr : R0Addr;
        mreq_q.push_back(m_req);
      end
    end else if (m_busy == 1) begin
      if (MVld || m_waited == TMO - 1) begin
        m_rsp.cyc  = cyc;
        m_rsp.port = m_win;
        m_rsp.data = MVld ? MData : '0;
        m_rsp.err  = !MVld;
        resp_q.push_back(m_rsp);
        m_busy = 2;
      end else begin
        m_waited++;
      end
    end else begin
      m_busy = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a memory request
  // or a port response.
  bit            prev_mrdy = 1'b0;
  logic [AW-1:0] cur_addr  = '0;
  mreq_t         got_req;
  resp_t         got_rsp;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("rst_mrdy",  MRdy, 0);
      check("rst_maddr", MAddr, 0);
      check("rst_vld",   {R0Vld, R1Vld}, 0);
      check("rst_err",   {R0Err, R1Err}, 0);
      check("rst_data",  {R0Data, R1Data}, 0);
      prev_mrdy = 1'b0;
    end else begin
      check("mrdy_level", MRdy, (m_busy == 1));
      if (MRdy && !prev_mrdy) begin
        if (mreq_q.size() == 0) begin
          record_fail("mreq_unexpected");
        end else begin
          got_req = mreq_q.pop_front();
          check("mreq_cycle", cyc, got_req.cyc);
          check("maddr", MAddr, got_req.addr);
          cur_addr = got_req.addr;
        end
      end
      if (MRdy) check("maddr_hold", MAddr, cur_addr);
      prev_mrdy = MRdy;

      if (R0Vld || R1Vld) begin
        check("vld_onehot", (R0Vld && R1Vld), 0);
        if (resp_q.size() == 0) begin
          record_fail("resp_unexpected");
        end else begin
          got_rsp = resp_q.pop_front();
          check("resp_cycle", cyc, got_rsp.cyc);
          check("resp_port", R1Vld, got_rsp.port);
          check("resp_data", got_rsp.port ? R1Data : R0Data, got_rsp.data);
          check("resp_err",  got_rsp.port ? R1Err : R0Err, got_rsp.err);
          check("loser_zero",
                got_rsp.port ? {R0Vld, R0Err, R0Data} : {R1Vld, R1Err, R1Data}, 0);
        end
      end else begin
        check("err_without_vld", {R0Err, R1Err}, 0);
      end
    end
  end

  task automatic drive_ports(input bit allow_new);
    if (R0Rdy && R0Vld) R0Rdy = 1'b0;
    else if (!R0Rdy && allow_new && $urandom_range(0, 1) == 1) begin
      R0Rdy  = 1'b1;
      R0Addr = $urandom;
    end else if (R0Rdy && m_busy == 1 && m_win == 1'b0 && $urandom_range(0, 3) == 0)
      R0Addr = $urandom;

    if (R1Rdy && R1Vld) R1Rdy = 1'b0;
    else if (!R1Rdy && allow_new && $urandom_range(0, 1) == 1) begin
      R1Rdy  = 1'b1;
      R1Addr = $urandom;
    end else if (R1Rdy && m_busy == 1 && m_win == 1'b1 && $urandom_range(0, 3) == 0)
      R1Addr = $urandom;
  endtask

  task automatic drive_mem();
    MData = $urandom;
    if (m_busy == 1 && m_waited == TMO - 1) MVld = ($urandom_range(0, 1) == 1);
    else                                   MVld = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    rst    = 1'b1;
    R0Rdy  = 1'b0;
    R1Rdy  = 1'b0;
    R0Addr = '0;
    R1Addr = '0;
    MVld   = 1'b0;
    MData  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
        drive_ports(1'b1);
        MVld  = 1'b1;
        MData = $urandom;
      end else if (m_busy == 1 && $urandom_range(0, 99) < 2) begin
        rst   = 1'b1;
        MVld  = 1'b1;
        MData = $urandom;
        #1;
        check("async_rst_mrdy", MRdy, 0);
        check("async_rst_vld", {R0Vld, R1Vld}, 0);
      end else begin
        drive_ports(1'b1);
        drive_mem();
      end
    end

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive_ports(1'b0);
      drive_mem();
    end
    @(negedge clk);
    MVld = 1'b0;
    repeat (4) @(negedge clk);

    check("drain_mreq", mreq_q.size(), 0);
    check("drain_resp", resp_q.size(), 0);
    check("drain_mrdy", MRdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
